// File: rtl/ram8_arbiter_if.sv
// Request/response/RAM bundle between two masters, the arbiter and a RAM8.
//   r0_*/r1_*      : valid/ready requests (we, addr, wdata) from masters 0 and 1
//   resp*_valid    : one-cycle response pulses, resp_rdata shared data
//   ram_*          : address/in/load to the RAM8, ram_out back from it
// slave modport is the arbiter side; master modport is the environment side.
interface ram8_arbiter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              r0_valid;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [WIDTH-1:0]  r0_wdata;
    logic              r0_ready;

    logic              r1_valid;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [WIDTH-1:0]  r1_wdata;
    logic              r1_ready;

    logic              resp0_valid;
    logic              resp1_valid;
    logic [WIDTH-1:0]  resp_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [WIDTH-1:0]  ram_in;
    logic              ram_load;
    logic [WIDTH-1:0]  ram_out;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready,
        output resp0_valid, resp1_valid, resp_rdata,
        output ram_address, ram_in, ram_load,
        input  ram_out
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready,
        input  resp0_valid, resp1_valid, resp_rdata,
        input  ram_address, ram_in, ram_load,
        output ram_out
    );
endinterface

// File: rtl/ram8_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for one RAM8.
// Pipeline: G (comb grant) -> A (command regs drive RAM) -> B (response regs).
// Ports:
//   clk    : clock, all state on posedge
//   reset  : synchronous active-high reset
//   bus    : ram8_arbiter_if.slave (requests, responses, RAM8 port)
module ram8_arbiter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    ram8_arbiter_if.slave  bus
);

    logic              grant0;
    logic              grant1;

    logic              last_winner_q, last_winner_d;
    logic              a_valid_q,     a_valid_d;
    logic              a_id_q,        a_id_d;
    logic              a_we_q,        a_we_d;
    logic [ADDR_W-1:0] a_addr_q,      a_addr_d;
    logic [WIDTH-1:0]  a_wdata_q,     a_wdata_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [WIDTH-1:0]  resp_rdata_q,  resp_rdata_d;

    // Grant and next-state logic. last_winner_q=1 means r1 won last, so a tie goes to r0.
    always_comb begin
        grant0        = 1'b0;
        grant1        = 1'b0;
        last_winner_d = last_winner_q;
        a_valid_d     = 1'b0;
        a_id_d        = a_id_q;
        a_we_d        = a_we_q;
        a_addr_d      = a_addr_q;
        a_wdata_d     = a_wdata_q;
        resp0_valid_d = a_valid_q & ~a_id_q;
        resp1_valid_d = a_valid_q &  a_id_q;
        resp_rdata_d  = resp_rdata_q;

        if (!reset) begin
            grant0 = bus.r0_valid & (~bus.r1_valid | last_winner_q);
            grant1 = bus.r1_valid & (~bus.r0_valid | ~last_winner_q);
        end

        if (grant0) begin
            last_winner_d = 1'b0;
            a_valid_d     = 1'b1;
            a_id_d        = 1'b0;
            a_we_d        = bus.r0_we;
            a_addr_d      = bus.r0_addr;
            a_wdata_d     = bus.r0_wdata;
        end else if (grant1) begin
            last_winner_d = 1'b1;
            a_valid_d     = 1'b1;
            a_id_d        = 1'b1;
            a_we_d        = bus.r1_we;
            a_addr_d      = bus.r1_addr;
            a_wdata_d     = bus.r1_wdata;
        end

        // Read data is ram_out before the write edge; writes echo their own data.
        if (a_valid_q) begin
            resp_rdata_d = a_we_q ? a_wdata_q : bus.ram_out;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_q <= 1'b1;
            a_valid_q     <= 1'b0;
            a_id_q        <= 1'b0;
            a_we_q        <= 1'b0;
            a_addr_q      <= ADDR_W'(0);
            a_wdata_q     <= WIDTH'(0);
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp_rdata_q  <= WIDTH'(0);
        end else begin
            last_winner_q <= last_winner_d;
            a_valid_q     <= a_valid_d;
            a_id_q        <= a_id_d;
            a_we_q        <= a_we_d;
            a_addr_q      <= a_addr_d;
            a_wdata_q     <= a_wdata_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

    assign bus.r0_ready    = grant0;
    assign bus.r1_ready    = grant1;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.ram_address = a_addr_q;
    assign bus.ram_in      = a_wdata_q;
    // Gating with reset drops an in-flight write instead of committing it.
    assign bus.ram_load    = a_valid_q & a_we_q & ~reset;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter with a behavioural RAM8; scoreboard queue of expected responses.
module tb_ram8_arbiter;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 3;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] ram_mem [8];
    logic [WIDTH-1:0] shadow  [8];

    ram8_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    ram8_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM8: combinational read, write on posedge when load.
    assign bus.ram_out = ram_mem[bus.ram_address];
    always @(posedge clk) begin
        if (bus.ram_load) ram_mem[bus.ram_address] <= bus.ram_in;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever a response pulse appears.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.resp0_valid && bus.resp1_valid)
                chk("resp_exclusive", 32'(1), 32'(0));
            if (bus.resp0_valid || bus.resp1_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp1_valid), 32'(2));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("resp_id",    32'(bus.resp1_valid), 32'(e.id));
                    chk("resp_rdata", 32'(bus.resp_rdata),  32'(e.data));
                    chk("resp_cycle", 32'(cyc),             32'(e.due));
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                chk("missing_resp", 32'(cyc), 32'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
        end
    end

    // One cycle: check readies against expected grants, record expected responses.
    task automatic step(input logic e0, input logic e1, input logic track);
        exp_t e;
        @(negedge clk);
        chk("r0_ready", 32'(bus.r0_ready), 32'(e0));
        chk("r1_ready", 32'(bus.r1_ready), 32'(e1));
        if (track && e0) begin
            e.id   = 1'b0;
            e.data = bus.r0_we ? bus.r0_wdata : shadow[bus.r0_addr];
            e.due  = cyc + 2;
            if (bus.r0_we) shadow[bus.r0_addr] = bus.r0_wdata;
            sb_q.push_back(e);
        end
        if (track && e1) begin
            e.id   = 1'b1;
            e.data = bus.r1_we ? bus.r1_wdata : shadow[bus.r1_addr];
            e.due  = cyc + 2;
            if (bus.r1_we) shadow[bus.r1_addr] = bus.r1_wdata;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic we, input int a, input logic [WIDTH-1:0] d);
        bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = ADDR_W'(a); bus.r0_wdata = d;
    endtask

    task automatic req1(input logic v, input logic we, input int a, input logic [WIDTH-1:0] d);
        bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = ADDR_W'(a); bus.r1_wdata = d;
    endtask

    task automatic idle(input int n);
        req0(1'b0, 1'b0, 0, 16'h0);
        req1(1'b0, 1'b0, 0, 16'h0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        for (int i = 0; i < 8; i++) begin
            ram_mem[i] = 16'h0000;
            shadow[i]  = 16'h0000;
        end
        reset = 1'b1;
        req0(1'b1, 1'b0, 0, 16'h0);
        req1(1'b1, 1'b0, 0, 16'h0);
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0);
        chk("rst_resp0",  32'(bus.resp0_valid), 32'(0));
        chk("rst_resp1",  32'(bus.resp1_valid), 32'(0));
        chk("rst_rdata",  32'(bus.resp_rdata),  32'(0));
        chk("rst_load",   32'(bus.ram_load),    32'(0));
        reset = 1'b0;

        // Both masters hold reads: strict alternation starting with r0.
        req0(1'b1, 1'b0, 1, 16'h0);
        req1(1'b1, 1'b0, 2, 16'h0);
        for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1, 1'b1);
        idle(3);

        // r0 write then read of the same address.
        req0(1'b1, 1'b1, 3, 16'hBEEF);
        step(1'b1, 1'b0, 1'b1);
        req0(1'b1, 1'b0, 3, 16'h0);
        step(1'b1, 1'b0, 1'b1);
        idle(3);
        chk("ram3", 32'(ram_mem[3]), 32'h0000BEEF);

        // r1 write then r0 read of the same address on the next cycle.
        req1(1'b1, 1'b1, 7, 16'h1234);
        step(1'b0, 1'b1, 1'b1);
        req1(1'b0, 1'b0, 0, 16'h0);
        req0(1'b1, 1'b0, 7, 16'h0);
        step(1'b1, 1'b0, 1'b1);
        idle(3);

        // r1 alone writes all eight words back-to-back, then r0 reads them back.
        req0(1'b0, 1'b0, 0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            req1(1'b1, 1'b1, i, 16'h0100 + 16'(i));
            step(1'b0, 1'b1, 1'b1);
        end
        req1(1'b0, 1'b0, 0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            req0(1'b1, 1'b0, i, 16'h0);
            step(1'b1, 1'b0, 1'b1);
        end
        idle(3);

        // Reset right after a granted write: write dropped, no response, r0 wins next tie.
        req0(1'b1, 1'b1, 5, 16'hAAAA);
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        req0(1'b1, 1'b0, 5, 16'h0);
        req1(1'b1, 1'b0, 5, 16'h0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        chk("post_rst_rdata", 32'(bus.resp_rdata), 32'(0));
        req0(1'b0, 1'b0, 0, 16'h0);
        step(1'b0, 1'b1, 1'b1);
        idle(4);
        chk("ram5_kept", 32'(ram_mem[5]), 32'h00000105);
        chk("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
